// File: rtl/ddr5_cmd_issuer_pkg.sv
// Shared types and default timing for the DDR5 command issuer.
// Timing values are in DRAM command-clock cycles.
package ddr5_cmd_issuer_pkg;

    typedef enum logic [1:0] {
        OP_READ   = 2'd0,
        OP_WRITE  = 2'd1,
        OP_IFETCH = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        CMD_ACT0 = 3'd0,
        CMD_ACT1 = 3'd1,
        CMD_RD0  = 3'd2,
        CMD_RD1  = 3'd3,
        CMD_WR0  = 3'd4,
        CMD_WR1  = 3'd5,
        CMD_PRE  = 3'd6,
        CMD_NOP  = 3'd7
    } cmd_e;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ACT0     = 4'd1,
        ST_ACT1     = 4'd2,
        ST_WAIT_RCD = 4'd3,
        ST_CAS0     = 4'd4,
        ST_CAS1     = 4'd5,
        ST_WAIT_PRE = 4'd6,
        ST_PRE      = 4'd7,
        ST_WAIT_RP  = 4'd8
    } state_e;

    // Field layout matches the address_mapping output.
    typedef struct packed {
        logic [2:0]  bg;
        logic [1:0]  bank;
        logic [15:0] row;
        logic [9:0]  col;
    } map_addr_t;

    localparam int unsigned DEF_T_RCD   = 32'd39;
    localparam int unsigned DEF_T_CL    = 32'd40;
    localparam int unsigned DEF_T_CWL   = 32'd38;
    localparam int unsigned DEF_T_BURST = 32'd8;
    localparam int unsigned DEF_T_WR    = 32'd30;
    localparam int unsigned DEF_T_RAS   = 32'd76;
    localparam int unsigned DEF_T_RP    = 32'd39;

    // Counter preload: a gap minus the cycles already spent in fixed states.
    function automatic logic [7:0] gap_load(input int unsigned cycles, input int unsigned overhead);
        if (cycles <= overhead) begin
            gap_load = 8'd0;
        end else if ((cycles - overhead) > 32'd255) begin
            gap_load = 8'hFF;
        end else begin
            gap_load = 8'(cycles - overhead);
        end
    endfunction

endpackage

// File: rtl/ddr5_cmd_issuer_if.sv
// Request handshake and command bus between the request queue, the issuer
// and the trace/statistics logic.
interface ddr5_cmd_issuer_if;

    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [2:0]  req_bg;
    logic [1:0]  req_bank;
    logic [15:0] req_row;
    logic [9:0]  req_col;

    logic        cmd_valid;
    logic [2:0]  cmd_code;
    logic [2:0]  cmd_bg;
    logic [1:0]  cmd_bank;
    logic [15:0] cmd_row;
    logic [9:0]  cmd_col;
    logic        done_valid;
    logic        busy;

    modport master (
        output req_valid, req_op, req_bg, req_bank, req_row, req_col,
        input  req_ready, cmd_valid, cmd_code, cmd_bg, cmd_bank, cmd_row, cmd_col,
        input  done_valid, busy
    );

    modport slave (
        input  req_valid, req_op, req_bg, req_bank, req_row, req_col,
        output req_ready, cmd_valid, cmd_code, cmd_bg, cmd_bank, cmd_row, cmd_col,
        output done_valid, busy
    );

endinterface

// File: rtl/ddr5_gap_counter.sv
// Loadable 8-bit down-counter that saturates at zero and flags it.
module ddr5_gap_counter (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    output logic       o_zero
);

    logic [7:0] r_count;

    // Load has priority; otherwise count down and hold at zero.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_count <= 8'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != 8'd0) begin
            r_count <= r_count - 8'd1;
        end else begin
            r_count <= 8'd0;
        end
    end

    assign o_zero = (r_count == 8'd0);

endmodule

// File: rtl/ddr5_cmd_issuer.sv
// Closed-page, in-order DDR5 command issuer: one request at a time is turned
// into ACT0/ACT1/CAS0/CAS1/PRE with timing gaps enforced by two counters.
module ddr5_cmd_issuer
    import ddr5_cmd_issuer_pkg::*;
#(
    parameter int unsigned T_RCD   = DEF_T_RCD,
    parameter int unsigned T_CL    = DEF_T_CL,
    parameter int unsigned T_CWL   = DEF_T_CWL,
    parameter int unsigned T_BURST = DEF_T_BURST,
    parameter int unsigned T_WR    = DEF_T_WR,
    parameter int unsigned T_RAS   = DEF_T_RAS,
    parameter int unsigned T_RP    = DEF_T_RP
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    ddr5_cmd_issuer_if.slave   io_bus
);

    // Preloads subtract the fixed one-cycle states that precede each exit.
    localparam logic [7:0] LD_RCD    = gap_load(T_RCD, 32'd3);
    localparam logic [7:0] LD_PRE_RD = gap_load(T_CL + T_BURST, 32'd3);
    localparam logic [7:0] LD_PRE_WR = gap_load(T_CWL + T_BURST + T_WR, 32'd3);
    localparam logic [7:0] LD_RP     = gap_load(T_RP, 32'd2);
    localparam logic [7:0] LD_RAS    = gap_load(T_RAS, 32'd1);

    state_e    r_state;
    op_e       r_op;
    map_addr_t r_addr;
    logic      r_cmd_valid;
    cmd_e      r_cmd_code;
    logic      r_done_valid;
    logic      r_busy;
    logic      r_req_ready;

    state_e    w_state_next;
    logic      w_xfer;
    logic      w_is_write;
    logic      w_gap_load;
    logic [7:0] w_gap_load_val;
    logic      w_gap_zero;
    logic      w_ras_zero;
    logic      w_cmd_valid;
    cmd_e      w_cmd_code;

    assign w_xfer     = io_bus.req_valid && r_req_ready;
    assign w_is_write = (r_op == OP_WRITE);

    ddr5_gap_counter u_gap_cnt (
        .i_clock    (i_clock),
        .i_reset_n  (i_reset_n),
        .i_load     (w_gap_load),
        .i_load_val (w_gap_load_val),
        .o_zero     (w_gap_zero)
    );

    // Loaded at acceptance so its value counts from the ACT0 cycle.
    ddr5_gap_counter u_ras_cnt (
        .i_clock    (i_clock),
        .i_reset_n  (i_reset_n),
        .i_load     (w_xfer),
        .i_load_val (LD_RAS),
        .o_zero     (w_ras_zero)
    );

    // State register.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:     w_state_next = w_xfer ? ST_ACT0 : ST_IDLE;
            ST_ACT0:     w_state_next = ST_ACT1;
            ST_ACT1:     w_state_next = ST_WAIT_RCD;
            ST_WAIT_RCD: w_state_next = w_gap_zero ? ST_CAS0 : ST_WAIT_RCD;
            ST_CAS0:     w_state_next = ST_CAS1;
            ST_CAS1:     w_state_next = ST_WAIT_PRE;
            ST_WAIT_PRE: w_state_next = (w_gap_zero && w_ras_zero) ? ST_PRE : ST_WAIT_PRE;
            ST_PRE:      w_state_next = ST_WAIT_RP;
            ST_WAIT_RP:  w_state_next = w_gap_zero ? ST_IDLE : ST_WAIT_RP;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    // Gap counter preload on the cycle before each wait state.
    always_comb begin
        w_gap_load     = 1'b0;
        w_gap_load_val = 8'd0;
        case (r_state)
            ST_ACT1: begin
                w_gap_load     = 1'b1;
                w_gap_load_val = LD_RCD;
            end
            ST_CAS1: begin
                w_gap_load     = 1'b1;
                w_gap_load_val = w_is_write ? LD_PRE_WR : LD_PRE_RD;
            end
            ST_PRE: begin
                w_gap_load     = 1'b1;
                w_gap_load_val = LD_RP;
            end
            default: begin
                w_gap_load     = 1'b0;
                w_gap_load_val = 8'd0;
            end
        endcase
    end

    // Command decode of the upcoming state, registered below.
    always_comb begin
        w_cmd_valid = 1'b0;
        w_cmd_code  = CMD_NOP;
        case (w_state_next)
            ST_ACT0: begin
                w_cmd_valid = 1'b1;
                w_cmd_code  = CMD_ACT0;
            end
            ST_ACT1: begin
                w_cmd_valid = 1'b1;
                w_cmd_code  = CMD_ACT1;
            end
            ST_CAS0: begin
                w_cmd_valid = 1'b1;
                w_cmd_code  = w_is_write ? CMD_WR0 : CMD_RD0;
            end
            ST_CAS1: begin
                w_cmd_valid = 1'b1;
                w_cmd_code  = w_is_write ? CMD_WR1 : CMD_RD1;
            end
            ST_PRE: begin
                w_cmd_valid = 1'b1;
                w_cmd_code  = CMD_PRE;
            end
            default: begin
                w_cmd_valid = 1'b0;
                w_cmd_code  = CMD_NOP;
            end
        endcase
    end

    // Registered outputs.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_cmd_valid  <= 1'b0;
            r_cmd_code   <= CMD_NOP;
            r_done_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_req_ready  <= 1'b0;
        end else begin
            r_cmd_valid  <= w_cmd_valid;
            r_cmd_code   <= w_cmd_code;
            r_done_valid <= (r_state == ST_WAIT_RP) && (w_state_next == ST_IDLE);
            r_busy       <= (w_state_next != ST_IDLE);
            r_req_ready  <= (w_state_next == ST_IDLE);
        end
    end

    // Holding registers, captured only on a transfer.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_op   <= OP_READ;
            r_addr <= '{bg: 3'd0, bank: 2'd0, row: 16'd0, col: 10'd0};
        end else if (w_xfer) begin
            r_op   <= op_e'(io_bus.req_op);
            r_addr <= '{bg: io_bus.req_bg, bank: io_bus.req_bank,
                        row: io_bus.req_row, col: io_bus.req_col};
        end else begin
            r_op   <= r_op;
            r_addr <= r_addr;
        end
    end

    assign io_bus.req_ready  = r_req_ready;
    assign io_bus.cmd_valid  = r_cmd_valid;
    assign io_bus.cmd_code   = r_cmd_code;
    assign io_bus.cmd_bg     = r_addr.bg;
    assign io_bus.cmd_bank   = r_addr.bank;
    assign io_bus.cmd_row    = r_addr.row;
    assign io_bus.cmd_col    = r_addr.col;
    assign io_bus.done_valid = r_done_valid;
    assign io_bus.busy       = r_busy;

endmodule

// File: tb/tb_ddr5_cmd_issuer.sv
// Directed bench for ddr5_cmd_issuer: a default-timing instance plus a
// T_RAS = 100 instance fed with the same requests.
module tb_ddr5_cmd_issuer;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    ddr5_cmd_issuer_if bus_a();
    ddr5_cmd_issuer_if bus_b();

    ddr5_cmd_issuer dut_a (
        .i_clock   (clk),
        .i_reset_n (reset_n),
        .io_bus    (bus_a)
    );

    ddr5_cmd_issuer #(.T_RAS(100)) dut_b (
        .i_clock   (clk),
        .i_reset_n (reset_n),
        .io_bus    (bus_b)
    );

    assign bus_b.req_valid = bus_a.req_valid;
    assign bus_b.req_op    = bus_a.req_op;
    assign bus_b.req_bg    = bus_a.req_bg;
    assign bus_b.req_bank  = bus_a.req_bank;
    assign bus_b.req_row   = bus_a.req_row;
    assign bus_b.req_col   = bus_a.req_col;

    int n_checks = 0;
    int n_pass   = 0;

    // Capture results of one request, times relative to the acceptance cycle.
    int t_code [8];
    int n_code [8];
    int t_done, n_done, t_ready, t_pre_b, t_done_b;
    bit fld_ok, acc_ok;

    task automatic run_req(input logic [1:0] op, input logic [2:0] bg, input logic [1:0] bank,
                           input logic [15:0] row, input logic [9:0] col,
                           input int max_cyc, input int rst_at);
        for (int i = 0; i < 8; i++) begin
            t_code[i] = -1;
            n_code[i] = 0;
        end
        t_done = -1; n_done = 0; t_ready = -1; t_pre_b = -1; t_done_b = -1; fld_ok = 1'b1;
        @(negedge clk);
        acc_ok = bus_a.req_ready;
        bus_a.req_op = op; bus_a.req_bg = bg; bus_a.req_bank = bank;
        bus_a.req_row = row; bus_a.req_col = col; bus_a.req_valid = 1'b1;
        for (int t = 1; t <= max_cyc; t++) begin
            @(negedge clk);
            bus_a.req_valid = 1'b0;
            if (bus_a.cmd_valid) begin
                if (t_code[bus_a.cmd_code] == -1) t_code[bus_a.cmd_code] = t;
                n_code[bus_a.cmd_code]++;
            end
            if (bus_a.done_valid) begin
                n_done++;
                if (t_done == -1) t_done = t;
            end
            if (bus_a.req_ready && t_ready == -1) t_ready = t;
            if (bus_a.busy && (bus_a.cmd_row !== row || bus_a.cmd_col !== col ||
                               bus_a.cmd_bg !== bg || bus_a.cmd_bank !== bank)) fld_ok = 1'b0;
            if (bus_b.cmd_valid && bus_b.cmd_code == 3'd6 && t_pre_b == -1) t_pre_b = t;
            if (bus_b.done_valid && t_done_b == -1) t_done_b = t;
            if (t == rst_at) reset_n = 1'b0;
            if (rst_at < 0 && t_done >= 0 && t_done_b >= 0 && t > t_done) break;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus_a.cmd_valid !== 1'b0) $display("FAIL rst_cmd_valid: got %b expected 0", bus_a.cmd_valid); else n_pass++;
        n_checks++; if (bus_a.cmd_code !== 3'd7) $display("FAIL rst_cmd_code: got %0d expected 7", bus_a.cmd_code); else n_pass++;
        n_checks++; if (bus_a.done_valid !== 1'b0) $display("FAIL rst_done: got %b expected 0", bus_a.done_valid); else n_pass++;
        n_checks++; if (bus_a.busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", bus_a.busy); else n_pass++;
        n_checks++; if (bus_a.req_ready !== 1'b0) $display("FAIL rst_ready_low: got %b expected 0", bus_a.req_ready); else n_pass++;
        n_checks++; if (bus_a.cmd_row !== 16'h0) $display("FAIL rst_row: got %h expected 0000", bus_a.cmd_row); else n_pass++;
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if (bus_a.req_ready !== 1'b1) $display("FAIL rst_ready_after: got %b expected 1", bus_a.req_ready); else n_pass++;
    endtask

    task automatic test_read();
        run_req(2'd0, 3'd3, 2'd1, 16'h1234, 10'h02A, 400, -1);
        n_checks++; if (acc_ok !== 1'b1) $display("FAIL rd_accept: got %b expected 1", acc_ok); else n_pass++;
        n_checks++; if (t_code[0] !== 1) $display("FAIL rd_act0: got %0d expected 1", t_code[0]); else n_pass++;
        n_checks++; if (t_code[1] !== 2) $display("FAIL rd_act1: got %0d expected 2", t_code[1]); else n_pass++;
        n_checks++; if (t_code[2] !== 40) $display("FAIL rd_rd0: got %0d expected 40", t_code[2]); else n_pass++;
        n_checks++; if (t_code[3] !== 41) $display("FAIL rd_rd1: got %0d expected 41", t_code[3]); else n_pass++;
        n_checks++; if (t_code[6] !== 88) $display("FAIL rd_pre: got %0d expected 88", t_code[6]); else n_pass++;
        n_checks++; if (t_done !== 127) $display("FAIL rd_done: got %0d expected 127", t_done); else n_pass++;
        n_checks++; if (t_ready !== 127) $display("FAIL rd_ready: got %0d expected 127", t_ready); else n_pass++;
        n_checks++; if (n_done !== 1) $display("FAIL rd_done_count: got %0d expected 1", n_done); else n_pass++;
        n_checks++; if (n_code[4] + n_code[5] !== 0) $display("FAIL rd_no_wr: got %0d expected 0", n_code[4] + n_code[5]); else n_pass++;
        n_checks++; if (n_code[0] + n_code[1] + n_code[2] + n_code[3] + n_code[6] !== 5) $display("FAIL rd_cmd_count: got %0d expected 5", n_code[0] + n_code[1] + n_code[2] + n_code[3] + n_code[6]); else n_pass++;
        n_checks++; if (fld_ok !== 1'b1) $display("FAIL rd_fields: got %b expected 1", fld_ok); else n_pass++;
    endtask

    task automatic test_write();
        run_req(2'd1, 3'd5, 2'd2, 16'hBEEF, 10'h155, 400, -1);
        n_checks++; if (t_code[0] !== 1) $display("FAIL wr_act0: got %0d expected 1", t_code[0]); else n_pass++;
        n_checks++; if (t_code[4] !== 40) $display("FAIL wr_wr0: got %0d expected 40", t_code[4]); else n_pass++;
        n_checks++; if (t_code[5] !== 41) $display("FAIL wr_wr1: got %0d expected 41", t_code[5]); else n_pass++;
        n_checks++; if (t_code[6] !== 116) $display("FAIL wr_pre: got %0d expected 116", t_code[6]); else n_pass++;
        n_checks++; if (t_done !== 155) $display("FAIL wr_done: got %0d expected 155", t_done); else n_pass++;
        n_checks++; if (n_code[2] + n_code[3] !== 0) $display("FAIL wr_no_rd: got %0d expected 0", n_code[2] + n_code[3]); else n_pass++;
        n_checks++; if (fld_ok !== 1'b1) $display("FAIL wr_fields: got %b expected 1", fld_ok); else n_pass++;
        n_checks++; if (t_done_b !== 155) $display("FAIL wr_done_tras100: got %0d expected 155", t_done_b); else n_pass++;
    endtask

    task automatic test_tras();
        // Reserved op 3 goes through the read path on both instances.
        run_req(2'd3, 3'd0, 2'd3, 16'h8001, 10'h3FF, 400, -1);
        n_checks++; if (t_code[6] !== 88) $display("FAIL tras_default_pre: got %0d expected 88", t_code[6]); else n_pass++;
        n_checks++; if (t_pre_b !== 101) $display("FAIL tras_bound_pre: got %0d expected 101", t_pre_b); else n_pass++;
        n_checks++; if (t_done_b !== 140) $display("FAIL tras_bound_done: got %0d expected 140", t_done_b); else n_pass++;
        n_checks++; if (t_code[2] !== 40) $display("FAIL rsvd_as_read: got %0d expected 40", t_code[2]); else n_pass++;
        n_checks++; if (n_code[4] !== 0) $display("FAIL rsvd_no_wr: got %0d expected 0", n_code[4]); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int n_acc = 0, n_act = 0, n_dn = 0, n_pre = 0;
        int t_acc2 = -1, t_act2 = -1, t_dn2 = -1;
        logic [15:0] pre_row [2];
        pre_row[0] = 16'h0; pre_row[1] = 16'h0;
        @(negedge clk);
        if (bus_a.req_ready) n_acc++;
        bus_a.req_op = 2'd0; bus_a.req_bg = 3'd1; bus_a.req_bank = 2'd0;
        bus_a.req_row = 16'hAAAA; bus_a.req_col = 10'h001; bus_a.req_valid = 1'b1;
        for (int t = 1; t <= 400; t++) begin
            @(negedge clk);
            if (t == 1) begin
                bus_a.req_bg = 3'd6; bus_a.req_bank = 2'd3; bus_a.req_row = 16'h5555; bus_a.req_col = 10'h2F0;
            end
            if (n_acc >= 2) bus_a.req_valid = 1'b0;
            if (bus_a.cmd_valid && bus_a.cmd_code == 3'd0) begin
                n_act++;
                if (n_act == 2) t_act2 = t;
            end
            if (bus_a.cmd_valid && bus_a.cmd_code == 3'd6) begin
                if (n_pre < 2) pre_row[n_pre] = bus_a.cmd_row;
                n_pre++;
            end
            if (bus_a.done_valid) begin
                n_dn++;
                if (n_dn == 2) t_dn2 = t;
            end
            if (bus_a.req_valid && bus_a.req_ready) begin
                n_acc++;
                if (n_acc == 2) t_acc2 = t;
            end
            if (n_dn >= 2 && t >= t_dn2 + 2) break;
        end
        bus_a.req_valid = 1'b0;
        n_checks++; if (n_acc !== 2) $display("FAIL b2b_accepts: got %0d expected 2", n_acc); else n_pass++;
        n_checks++; if (t_acc2 !== 127) $display("FAIL b2b_accept2: got %0d expected 127", t_acc2); else n_pass++;
        n_checks++; if (t_act2 !== 128) $display("FAIL b2b_act0_2: got %0d expected 128", t_act2); else n_pass++;
        n_checks++; if (n_act !== 2) $display("FAIL b2b_act_count: got %0d expected 2", n_act); else n_pass++;
        n_checks++; if (t_dn2 !== 254) $display("FAIL b2b_done2: got %0d expected 254", t_dn2); else n_pass++;
        n_checks++; if (n_dn !== 2) $display("FAIL b2b_done_count: got %0d expected 2", n_dn); else n_pass++;
        n_checks++; if (pre_row[0] !== 16'hAAAA) $display("FAIL b2b_row1: got %h expected aaaa", pre_row[0]); else n_pass++;
        n_checks++; if (pre_row[1] !== 16'h5555) $display("FAIL b2b_row2: got %h expected 5555", pre_row[1]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        run_req(2'd0, 3'd2, 2'd3, 16'h0F0F, 10'h3FF, 200, 50);
        n_checks++; if (acc_ok !== 1'b1) $display("FAIL mid_accept: got %b expected 1", acc_ok); else n_pass++;
        n_checks++; if (t_code[2] !== 40) $display("FAIL mid_rd0: got %0d expected 40", t_code[2]); else n_pass++;
        n_checks++; if (t_code[6] !== -1) $display("FAIL mid_no_pre: got %0d expected -1", t_code[6]); else n_pass++;
        n_checks++; if (n_done !== 0) $display("FAIL mid_no_done: got %0d expected 0", n_done); else n_pass++;
        n_checks++; if (t_done_b !== -1) $display("FAIL mid_no_done_b: got %0d expected -1", t_done_b); else n_pass++;
        n_checks++; if (bus_a.busy !== 1'b0) $display("FAIL mid_busy: got %b expected 0", bus_a.busy); else n_pass++;
        n_checks++; if (bus_a.cmd_row !== 16'h0) $display("FAIL mid_row_cleared: got %h expected 0000", bus_a.cmd_row); else n_pass++;
        reset_n = 1'b1;
        run_req(2'd1, 3'd1, 2'd0, 16'h00AA, 10'h001, 400, -1);
        n_checks++; if (acc_ok !== 1'b1) $display("FAIL post_accept: got %b expected 1", acc_ok); else n_pass++;
        n_checks++; if (t_code[0] !== 1) $display("FAIL post_act0: got %0d expected 1", t_code[0]); else n_pass++;
        n_checks++; if (t_code[4] !== 40) $display("FAIL post_wr0: got %0d expected 40", t_code[4]); else n_pass++;
        n_checks++; if (t_done !== 155) $display("FAIL post_done: got %0d expected 155", t_done); else n_pass++;
    endtask

    initial begin
        bus_a.req_valid = 1'b0; bus_a.req_op = 2'd0; bus_a.req_bg = 3'd0;
        bus_a.req_bank = 2'd0; bus_a.req_row = 16'd0; bus_a.req_col = 10'd0;
        test_reset();
        test_read();
        test_write();
        test_tras();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ddr5_cmd_issuer.md
# ddr5_cmd_issuer

Dequeue and issue end of the DDR5 scheduler. It pops one mapped request at a time from the request queue using a valid/ready handshake. For each request it drives the DDR5 command sequence ACT0, ACT1, RD0/RD1 or WR0/WR1, then PRE, under a closed-page, strictly in-order policy. All JEDEC-style timing gaps are enforced by internal counters, and completion is signalled back to the trace/statistics logic.

## Interface
Parameters (all in DRAM command-clock cycles, each 1..255):
- T_RCD, 39, ACT0 start to CAS0 start
- T_CL, 40, read CAS latency
- T_CWL, 38, write CAS latency
- T_BURST, 8, data burst length
- T_WR, 30, write recovery, from end of write burst to PRE
- T_RAS, 76, minimum ACT0 start to PRE
- T_RP, 39, PRE to bank idle

Ports:
- clock  in  1  single clock; everything is synchronous to its rising edge
- reset_n  in  1  reset; synchronous and active-low
- req_valid  in  1  queue head holds a request
- req_ready  out  1  issuer can accept a request
- req_op  in  2  0 = data read, 1 = data write, 2 = instruction fetch (treated as a read), 3 = reserved (treated as a read)
- req_bg  in  3  bank group
- req_bank  in  2  bank
- req_row  in  16  row
- req_col  in  10  column
- cmd_valid  out  1  a command is on the cmd_* outputs this cycle
- cmd_code  out  3  ACT0 = 0, ACT1 = 1, RD0 = 2, RD1 = 3, WR0 = 4, WR1 = 5, PRE = 6, NOP = 7
- cmd_bg  out  3  bank group of the current request
- cmd_bank  out  2  bank of the current request
- cmd_row  out  16  row of the current request
- cmd_col  out  10  column of the current request
- done_valid  out  1  one-cycle pulse when the current request retires
- busy  out  1  high whenever the issuer is not IDLE

## Operation
- Handshake: a transfer occurs when req_valid && req_ready. req_ready = (state == IDLE). On transfer, op/bg/bank/row/col are latched into holding registers and stay stable until retirement.
- State sequence: IDLE → ACT0 → ACT1 → WAIT_RCD → CAS0 → CAS1 → WAIT_PRE → PRE → WAIT_RP → IDLE.
- Each of ACT0, ACT1, CAS0, CAS1 and PRE lasts exactly one cycle. In that cycle cmd_valid = 1 and cmd_code is the matching code. CAS0/CAS1 emit RD0/RD1 for reads and WR0/WR1 for writes.
- In every other state: cmd_valid = 0, cmd_code = NOP.
- cmd_bg, cmd_bank, cmd_row and cmd_col always reflect the holding registers.
- Gap counter: an 8-bit down-counter, loaded on entry to WAIT_RCD, WAIT_PRE and WAIT_RP.
- tRAS counter: an independent 8-bit down-counter, loaded with T_RAS−1 in the ACT0 cycle and saturating at 0.
- PRE is issued only when both counters allow it: PRE start = max(ACT0 + T_RAS, CAS0 + L + T_BURST (+ T_WR for writes)), where L = T_CL for reads and T_CWL for writes.
- Retirement: WAIT_RP exits to IDLE at PRE + T_RP. done_valid pulses in that same cycle.
- Outputs registered; reset values: req_ready = 0 during reset then 1; cmd_valid = 0; cmd_code = NOP; cmd_* fields = 0; done_valid = 0; busy = 0; both counters = 0.

## Timing
All cycle numbers below are relative to the acceptance cycle a.
- ACT0 at a+1, ACT1 at a+2.
- CAS0 at a+1+T_RCD, CAS1 one cycle later.
- PRE per the rule in Operation. IDLE, done_valid and req_ready all occur at PRE + T_RP.
- A new request may be accepted in the same cycle done_valid pulses, giving back-to-back operation with no bubble beyond T_RP.
- reset_n low at any point: next edge forces IDLE and all reset values. The in-flight request is dropped and no done_valid is produced.
- req_valid deasserting while req_ready = 0 has no effect. Request fields are sampled only at transfer.
- Reserved req_op = 3 is treated as a read.

## Structure
- Shared declarations package holds:
  - the op enum and the cmd_code enum;
  - the mapped-address struct (bg/bank/row/col), which must match the address_mapping output fields;
  - the default timing constants.
- One sub-module, ddr5_gap_counter: a loadable 8-bit down-counter with a zero flag and synchronous active-low reset. It is instantiated twice, once for the gap counter and once for the tRAS counter.
- FSM and holding registers live in ddr5_cmd_issuer.

## Test plan
- Reset: hold reset_n = 0 for 3 cycles → cmd_valid = 0, cmd_code = 7, done_valid = 0, busy = 0. req_ready = 1 from the first cycle after release.
- Single read (default parameters; op 0, bg 3, bank 1, row 0x1234, col 0x2A) accepted at cycle 0 → ACT0 at 1, ACT1 at 2, RD0 at 40, RD1 at 41, PRE at 88, done_valid and req_ready at 127; cmd_row = 0x1234 throughout.
- Single write (op 1) accepted at 0 → WR0 at 40, WR1 at 41, PRE at 116, done_valid at 155.
- Back-to-back: two reads queued with req_valid held high → second accepted at 127, its ACT0 at 128; no request is lost or duplicated.
- tRAS-bound: T_RAS = 100, read → PRE at 101, not 88.
- Reset mid-operation: reset_n = 0 at cycle 50 of a read → no PRE and no done_valid. After release, a new request is accepted and its ACT0 appears one cycle after acceptance.
